shared_reg_arbiter: RTL

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: four requesters compete round-robin for a single shared
// data register. A winner is granted, its write slice is loaded into q one
// cycle later, and the grant is held until the owner drops its request or the
// hold limit expires. A forced release is flagged by a one-cycle timeout pulse.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [3:0] request line per requester
//   wr_data  in   [4*WIDTH-1:0] packed write data, requester i at [i*WIDTH +: WIDTH]
//   grant    out  [3:0] one-hot grant to the current owner, zero when idle
//   owner    out  [1:0] index of the current or most recent owner
//   ack      out  owner's data is held in q
//   q        out  [WIDTH-1:0] shared register contents
//   busy     out  FSM is not idle
//   timeout  out  one-cycle pulse on forced release
module shared_reg_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   wr_data,
    output logic [3:0]           grant,
    output logic [1:0]           owner,
    output logic                 ack,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 timeout
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_grant;
    logic [1:0]         r_owner;
    logic [1:0]         r_last;
    logic               r_ack;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [3:0]         w_grant_nxt;
    logic [1:0]         w_owner_nxt;
    logic [1:0]         w_last_nxt;
    logic               w_ack_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_busy_nxt;
    logic               w_timeout_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [1:0]         w_winner;
    logic [1:0]         w_idx;
    logic [WIDTH-1:0]   w_slice;
    logic               w_release;

    // Round-robin pick starting after the last owner; scanning from the far
    // end lets the nearest requesting index overwrite the result last.
    always_comb begin
        w_winner = r_last;
        w_idx    = r_last;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = r_last + 2'(i);
            if (req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    assign w_slice   = wr_data[r_owner*WIDTH +: WIDTH];
    assign w_release = !req[r_owner] || (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_ack_nxt     = r_ack;
        w_q_nxt       = r_q;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    w_grant_nxt = 4'(1) << w_winner;
                    w_owner_nxt = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            // LOAD completes unconditionally, even if the request drops.
            S_LOAD: begin
                w_q_nxt     = w_slice;
                w_ack_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_release) begin
                    w_grant_nxt   = 4'b0000;
                    w_ack_nxt     = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_last_nxt    = r_owner;
                    // Still requesting at release means the hold limit forced it.
                    w_timeout_nxt = req[r_owner];
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_grant   <= 4'b0000;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_ack     <= 1'b0;
            r_q       <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_ack     <= w_ack_nxt;
            r_q       <= w_q_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign grant   = r_grant;
    assign owner   = r_owner;
    assign ack     = r_ack;
    assign q       = r_q;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
